// File: rtl/psx_device_port.sv
// PSX controller-port device responder: byte shift engine plus ACK pulse timer.
// DATA/ACK are open-drain, so both outputs are pull-low enables.
`timescale 1ns/1ps
module psx_device_port #(
  parameter int unsigned ACK_DELAY = 100,
  parameter int unsigned ACK_WIDTH = 50,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psx_att_n,
  input  logic       psx_clk,
  input  logic       psx_cmd,
  output logic       psx_dat_oe,
  output logic       psx_ack_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_ack,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       selected
);

  typedef enum logic [1:0] {
    ACK_IDLE,
    ACK_WAIT,
    ACK_PULSE
  } ack_st_e;

  localparam logic [15:0] DLY_LAST = 16'(ACK_DELAY - 1);
  localparam logic [15:0] WID_LAST = 16'(ACK_WIDTH - 1);

  logic        clk_prev_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  tx_sr_q;
  logic [7:0]  rx_sr_q;
  logic        ack_req_q;
  ack_st_e     ack_st_q;
  logic [15:0] ack_cnt_q;
  logic        dat_oe_q;
  logic        ack_oe_q;
  logic        tx_ready_q;
  logic        rx_strobe_q;
  logic [7:0]  rx_data_q;
  logic        selected_q;

  logic       fall;
  logic       rise;
  logic       last_bit;
  logic [7:0] ld_byte;

  assign fall     = clk_prev_q & ~psx_clk;
  assign rise     = ~clk_prev_q & psx_clk;
  assign last_bit = (bit_cnt_q == 3'd7);
  assign ld_byte  = tx_valid ? tx_data : IDLE_BYTE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      tx_sr_q     <= 8'h00;
      rx_sr_q     <= 8'h00;
      ack_req_q   <= 1'b0;
      ack_st_q    <= ACK_IDLE;
      ack_cnt_q   <= 16'd0;
      dat_oe_q    <= 1'b0;
      ack_oe_q    <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_strobe_q <= 1'b0;
      rx_data_q   <= 8'h00;
      selected_q  <= 1'b0;
    end else begin
      clk_prev_q  <= psx_clk;
      selected_q  <= ~psx_att_n;
      tx_ready_q  <= 1'b0;
      rx_strobe_q <= 1'b0;
      if (psx_att_n) begin
        bit_cnt_q <= 3'd0;
        ack_req_q <= 1'b0;
        ack_st_q  <= ACK_IDLE;
        dat_oe_q  <= 1'b0;
        ack_oe_q  <= 1'b0;
      end else begin
        if (fall) begin
          if (bit_cnt_q == 3'd0) begin
            tx_sr_q    <= ld_byte;
            ack_req_q  <= tx_valid & tx_ack;
            tx_ready_q <= tx_valid;
            dat_oe_q   <= ~ld_byte[0];
          end else begin
            dat_oe_q <= ~tx_sr_q[bit_cnt_q];
          end
        end
        if (rise) begin
          rx_sr_q[bit_cnt_q] <= psx_cmd;
          bit_cnt_q          <= bit_cnt_q + 3'd1;
          if (last_bit) begin
            rx_data_q   <= {psx_cmd, rx_sr_q[6:0]};
            rx_strobe_q <= 1'b1;
          end
        end
        unique case (ack_st_q)
          ACK_IDLE: begin
            if (rise && last_bit && ack_req_q) begin
              ack_st_q  <= ACK_WAIT;
              ack_cnt_q <= 16'd0;
            end
          end
          ACK_WAIT: begin
            // console already clocking the next byte: ACK no longer wanted
            if (fall) begin
              ack_st_q <= ACK_IDLE;
            end else if (ack_cnt_q == DLY_LAST) begin
              ack_st_q  <= ACK_PULSE;
              ack_cnt_q <= 16'd0;
              ack_oe_q  <= 1'b1;
            end else begin
              ack_cnt_q <= ack_cnt_q + 16'd1;
            end
          end
          ACK_PULSE: begin
            if (ack_cnt_q == WID_LAST) begin
              ack_st_q <= ACK_IDLE;
              ack_oe_q <= 1'b0;
            end else begin
              ack_cnt_q <= ack_cnt_q + 16'd1;
            end
          end
          default: ack_st_q <= ACK_IDLE;
        endcase
      end
    end
  end

  assign psx_dat_oe = dat_oe_q;
  assign psx_ack_oe = ack_oe_q;
  assign tx_ready   = tx_ready_q;
  assign rx_strobe  = rx_strobe_q;
  assign rx_data    = rx_data_q;
  assign selected   = selected_q;

endmodule

// File: doc/psx_device_port.md
# psx_device_port

Byte-level PlayStation controller-port responder: the device (controller) end of the PSX serial link.
- Inputs: ATT, CLK and CMD, already passed through the two-flop input synchronizers.
- Outputs: the open-drain DATA and ACK lines, driven as pull-low enables.
- Deserializes command bytes from the console and serializes reply bytes from a simple valid/ready source.
- Generates the per-byte ACK pulse.
- Sits between the synchronized pad inputs and the controller-emulation logic.

## Interface
- ACK_DELAY, 100: clk cycles from rx_strobe to start of ACK pulse; must be >= 1.
- ACK_WIDTH, 50: clk cycles ACK is held low; must be >= 1.
- IDLE_BYTE, 8'hFF: reply byte used when no tx byte is available.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- psx_att_n  in  1  synchronized ATT; low = device selected.
- psx_clk  in  1  synchronized PSX CLK; idles high.
- psx_cmd  in  1  synchronized CMD line.
- psx_dat_oe  out  1  1 = pull DATA low.
- psx_ack_oe  out  1  1 = pull ACK low.
- tx_data  in  8  next reply byte.
- tx_valid  in  1  tx_data/tx_ack valid.
- tx_ack  in  1  request ACK after this byte; sampled with tx_data.
- tx_ready  out  1  one-cycle pulse: tx_data consumed.
- rx_data  out  8  last complete command byte.
- rx_strobe  out  1  one-cycle pulse: rx_data updated.
- selected  out  1  registered copy of ~psx_att_n.

## Operation
- Edge detect: register psx_clk into clk_prev (reset value 1).
  - fall = clk_prev & ~psx_clk.
  - rise = ~clk_prev & psx_clk.
- Protocol: LSB first. Device changes DATA on fall; both sides sample on rise.
- Shift engine: 3-bit bit_cnt, tx shift register, rx shift register, ack_req flag.
  - Fall with bit_cnt==0:
    - If tx_valid: load tx_data, ack_req <= tx_ack, pulse tx_ready.
    - Else: load IDLE_BYTE, ack_req <= 0, no tx_ready.
    - Drive psx_dat_oe <= ~byte[0].
  - Fall with bit_cnt==n (n=1..7): psx_dat_oe <= ~tx_sr[n].
  - Rise: rx_sr[bit_cnt] <= psx_cmd; bit_cnt <= bit_cnt+1, wrapping 7 -> 0.
  - Rise with bit_cnt==7: rx_data <= completed byte (including this bit); pulse rx_strobe; if ack_req, start the ACK FSM.
  - psx_dat_oe holds the last bit until the next fall or deselect.
- ACK FSM: states ACK_IDLE, ACK_WAIT, ACK_PULSE, with a 16-bit counter.
  - ACK_IDLE -> ACK_WAIT on a byte completion with ack_req; counter loaded.
  - ACK_WAIT -> ACK_PULSE after ACK_DELAY cycles.
  - ACK_PULSE -> ACK_IDLE after ACK_WIDTH cycles.
  - psx_ack_oe = 1 only in ACK_PULSE.
  - A fall seen in ACK_WAIT cancels the ACK: return to ACK_IDLE with no pulse. The fall is still processed by the shift engine.
  - ACK_PULSE always runs to completion, except on deselect.
- Deselect: psx_att_n high forces the following every cycle; rise and fall are ignored while deselected, and a partial byte produces no rx_strobe.
  - bit_cnt=0, ack_req=0, ACK FSM to ACK_IDLE.
  - psx_dat_oe=0, psx_ack_oe=0.
- Selection gating: a fall or rise is processed only if psx_att_n is low in the same cycle.
- Reset values:
  - psx_dat_oe=0, psx_ack_oe=0, tx_ready=0, rx_strobe=0, selected=0.
  - rx_data=8'h00, bit_cnt=0, ACK_IDLE.

## Timing
- All outputs are registered.
- psx_dat_oe changes 1 clk after the cycle in which fall is detected.
- tx_ready pulses in the same cycle psx_dat_oe takes bit 0.
- tx_data must be stable when fall is detected with bit_cnt==0.
- rx_strobe and rx_data update 1 clk after the 8th rise is detected.
- If rx_strobe is high in cycle T, psx_ack_oe is high in cycles T+ACK_DELAY through T+ACK_DELAY+ACK_WIDTH-1.
- Deselect takes effect 1 clk after psx_att_n is seen high.
- The block tolerates PSX CLK half-periods >= 2 clk. Shorter half-periods are unsupported.

## Test plan
- Select; console clocks CMD 8'h01; tx_valid with tx_data=8'h41, tx_ack=1.
  - DATA (the inverse of psx_dat_oe) reads 1,0,0,0,0,0,1,0 on successive rises.
  - rx_data=8'h01 with a single rx_strobe.
  - psx_ack_oe high for exactly 50 cycles, starting 100 cycles after rx_strobe.
- tx_valid=0 during a byte: reply is 8'hFF (psx_dat_oe stays 0), no tx_ready, no ACK.
- Three-byte transaction 01/42/00 with replies FF/41/5A and tx_ack=1,1,0.
  - rx_strobe x3 with correct bytes.
  - Exactly two ACK pulses.
- psx_att_n raised after 4 bits: next cycle psx_dat_oe=0, no rx_strobe. Next selection starts at bit 0 with a fresh tx load.
- psx_att_n raised during ACK_PULSE: psx_ack_oe drops the next cycle. Fall during ACK_WAIT: no ACK pulse.
- reset asserted mid-byte: all outputs return to their reset values immediately. The first byte after reset decodes correctly.
